fft_sched: RTL and testbench

In-place radix-2 decimation-in-time (DIT) scheduler for the 1024-point FFT butterfly datapath.
- Sequences every stage and butterfly of the transform.
- Generates butterfly read addresses and twiddle indices for the shared X_Re/X_Im sample memory.
- Issues delayed write-back strobes that match the butterfly pipeline latency.
- Handshakes with the top-level record/play state machine through Start/Done/Ack.
- Honours a Hold request, so the top level can borrow the sample memory mid-transform.

---
 rtl/fft_sched_if.sv | 30 +++
 rtl/fft_sched.sv | 152 +++++++++++++++
 tb/tb_fft_sched.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_sched_if.sv
// Handshake and address bus between the FFT scheduler and the top-level
// record/play controller. The controller side is the master; the scheduler
// side is the slave.
interface fft_sched_if #(
  parameter int LOG2N = 10
) ();
  logic             Start;
  logic             Ack;
  logic             Hold;
  logic             rd_en;
  logic [LOG2N-1:0] i_top;
  logic [LOG2N-1:0] i_bot;
  logic [LOG2N-2:0] tw_idx;
  logic             wr_en;
  logic [LOG2N-1:0] wr_top;
  logic [LOG2N-1:0] wr_bot;
  logic [3:0]       stage;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, Ack, Hold,
    input  rd_en, i_top, i_bot, tw_idx, wr_en, wr_top, wr_bot, stage, Busy, Done
  );

  modport slave (
    input  Start, Ack, Hold,
    output rd_en, i_top, i_bot, tw_idx, wr_en, wr_top, wr_bot, stage, Busy, Done
  );
endinterface

// File: rtl/fft_sched.sv
// In-place radix-2 DIT scheduler: walks every stage and butterfly of an
// N-point transform, issues read addresses and twiddle indices, and replays
// each issue as a write-back strobe PIPE_LAT cycles later.
module fft_sched #(
  parameter int LOG2N    = 10,
  parameter int PIPE_LAT = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  fft_sched_if.slave  bus
);

  localparam int BW = LOG2N - 1;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [BW-1:0] LAST_B = '1;
  localparam logic [3:0]    LAST_S = 4'(LOG2N - 1);
  localparam logic [DW-1:0] LAST_D = DW'(PIPE_LAT - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    RUN   = 4'b0010,
    DRAIN = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  state_t          state;
  logic [3:0]      s;
  logic [BW-1:0]   b;
  logic [DW-1:0]   d;

  logic [LOG2N-1:0] mask;
  logic [LOG2N-1:0] b_ext;
  logic [LOG2N-1:0] top_c;
  logic [LOG2N-1:0] bot_c;
  logic [BW-1:0]    tw_c;

  // Butterfly addressing: insert a zero at bit s of b for the top operand,
  // set that bit for the bottom one; twiddle is the low s bits scaled up.
  always_comb begin
    // NOTE: every signal here is assigned on every pass, so no latch can form.
    mask  = (LOG2N'(1) << s) - LOG2N'(1);
    b_ext = {1'b0, b};
    top_c = ((b_ext & ~mask) << 1) | (b_ext & mask);
    bot_c = top_c | (LOG2N'(1) << s);
    tw_c  = (b & mask[BW-1:0]) << (4'(LOG2N - 1) - s);
  end

  // Control FSM with registered issue, status and address outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      s          <= '0;
      b          <= '0;
      d          <= '0;
      bus.rd_en  <= 1'b0;
      bus.i_top  <= '0;
      bus.i_bot  <= '0;
      bus.tw_idx <= '0;
      bus.Busy   <= 1'b0;
      bus.Done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register sample pre-edge values.
      bus.rd_en <= 1'b0;
      case (state)
        IDLE: begin
          s <= '0;
          b <= '0;
          d <= '0;
          if (bus.Start) begin
            state    <= RUN;
            bus.Busy <= 1'b1;
          end
        end
        RUN: begin
          if (!bus.Hold) begin
            bus.rd_en  <= 1'b1;
            bus.i_top  <= top_c;
            bus.i_bot  <= bot_c;
            bus.tw_idx <= tw_c;
            // b wraps to zero after the last butterfly, ready for the next stage.
            b <= b + 1'b1;
            if (b == LAST_B) begin
              state <= DRAIN;
              d     <= '0;
            end
          end
        end
        DRAIN: begin
          // Let every write of this stage land before the next stage reads.
          if (d == LAST_D) begin
            d <= '0;
            if (s < LAST_S) begin
              s     <= s + 4'd1;
              state <= RUN;
            end else begin
              state    <= DONE;
              bus.Busy <= 1'b0;
            end
          end else begin
            d <= d + 1'b1;
          end
        end
        DONE: begin
          // Done shows one cycle after entry; Ack counts only once it is visible.
          bus.Done <= 1'b1;
          if (bus.Done && bus.Ack) begin
            bus.Done <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          bus.Busy <= 1'b0;
          bus.Done <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stage = s;

  logic             pipe_v   [PIPE_LAT];
  logic [LOG2N-1:0] pipe_top [PIPE_LAT];
  logic [LOG2N-1:0] pipe_bot [PIPE_LAT];

  // Write-back delay line; shifts every cycle irrespective of state or Hold.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      // NOTE: address fields are reset too so wr_top/wr_bot read 0; this is a short register chain, not a RAM.
      for (int i = 0; i < PIPE_LAT; i++) begin
        pipe_v[i]   <= 1'b0;
        pipe_top[i] <= '0;
        pipe_bot[i] <= '0;
      end
    end else begin
      pipe_v[0]   <= bus.rd_en;
      pipe_top[0] <= bus.i_top;
      pipe_bot[0] <= bus.i_bot;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_top[i] <= pipe_top[i-1];
        pipe_bot[i] <= pipe_bot[i-1];
      end
    end
  end

  assign bus.wr_en  = pipe_v[PIPE_LAT-1];
  assign bus.wr_top = pipe_top[PIPE_LAT-1];
  assign bus.wr_bot = pipe_bot[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_sched.sv
// Self-checking bench for fft_sched: a scoreboard of expected butterfly
// issues is loaded whenever a transform is started, and every rd_en/wr_en
// the DUT produces is popped and compared. A second small instance
// (LOG2N=3, PIPE_LAT=1) is stepped cycle by cycle against a direct model.
module tb_fft_sched;

  localparam int LOG2N    = 10;
  localparam int PIPE_LAT = 2;
  localparam int NB       = 1 << (LOG2N - 1);
  localparam int RUN_CYC  = LOG2N * (NB + PIPE_LAT);

  localparam int L2_S  = 3;
  localparam int NB_S  = 1 << (L2_S - 1);
  localparam int PL_S  = 1;
  localparam int RUN_S = L2_S * (NB_S + PL_S);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_sched_if #(.LOG2N(LOG2N)) bus ();
  fft_sched_if #(.LOG2N(L2_S))  bus2 ();

  fft_sched #(.LOG2N(LOG2N), .PIPE_LAT(PIPE_LAT)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  fft_sched #(.LOG2N(L2_S), .PIPE_LAT(PL_S)) dut_small (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus2)
  );

  typedef struct { int top; int bot; int tw; int st; } issue_t;
  typedef struct { int top; int bot; int due; } wr_t;

  issue_t exp_q[$];
  wr_t    wq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rd_count = 0;
  int wr_count = 0;
  int first_rd_cyc = -1;
  int rd511_cyc = 0;
  int rd512_cyc = 0;
  int start_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference addressing taken straight from the butterfly definition.
  function automatic issue_t model_issue(input int log2n, input int st, input int bf);
    issue_t e;
    int span;
    span  = 1 << st;
    e.top = ((bf >> st) << (st + 1)) | (bf & (span - 1));
    e.bot = e.top + span;
    e.tw  = (bf & (span - 1)) << (log2n - 1 - st);
    e.st  = st;
    return e;
  endfunction

  task automatic push_transform();
    for (int st = 0; st < LOG2N; st++)
      for (int bf = 0; bf < NB; bf++)
        exp_q.push_back(model_issue(LOG2N, st, bf));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pop one expected issue per rd_en, one expected write per wr_en.
  always @(negedge clk) begin
    if (bus.rd_en === 1'b1) begin
      check("rd_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        issue_t e;
        e = exp_q.pop_front();
        check("rd_top",   32'(bus.i_top),  e.top);
        check("rd_bot",   32'(bus.i_bot),  e.bot);
        check("rd_tw",    32'(bus.tw_idx), e.tw);
        check("rd_stage", 32'(bus.stage),  e.st);
        wq.push_back('{top: e.top, bot: e.bot, due: cyc + PIPE_LAT});
      end
      if (rd_count == 0)   first_rd_cyc = cyc;
      if (rd_count == 511) rd511_cyc = cyc;
      if (rd_count == 512) rd512_cyc = cyc;
      rd_count++;
    end
    if (bus.wr_en === 1'b1) begin
      check("wr_expected", 32'(wq.size() != 0), 1);
      if (wq.size() != 0) begin
        wr_t w;
        w = wq.pop_front();
        check("wr_top",   32'(bus.wr_top), w.top);
        check("wr_bot",   32'(bus.wr_bot), w.bot);
        check("wr_cycle", cyc, w.due);
      end
      wr_count++;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_rd_en"},  32'(bus.rd_en),  0);
    check({tag, "_wr_en"},  32'(bus.wr_en),  0);
    check({tag, "_i_top"},  32'(bus.i_top),  0);
    check({tag, "_i_bot"},  32'(bus.i_bot),  0);
    check({tag, "_tw_idx"}, 32'(bus.tw_idx), 0);
    check({tag, "_wr_top"}, 32'(bus.wr_top), 0);
    check({tag, "_wr_bot"}, 32'(bus.wr_bot), 0);
    check({tag, "_stage"},  32'(bus.stage),  0);
    check({tag, "_busy"},   32'(bus.Busy),   0);
    check({tag, "_done"},   32'(bus.Done),   0);
  endtask

  task automatic wait_rd(input int target, input int budget);
    int i = 0;
    while (rd_count < target && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
    check("wait_rd_reached", 32'(rd_count >= target), 1);
  endtask

  // Load the scoreboard, then pulse Start for one sampled edge.
  task automatic start_run();
    rd_count     = 0;
    wr_count     = 0;
    first_rd_cyc = -1;
    push_transform();
    bus.Start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    bus.Start = 1'b0;
    check("busy_after_start", 32'(bus.Busy), 1);
  endtask

  task automatic finish_run(input int extra);
    int i = 0;
    while (bus.Done !== 1'b1 && i < RUN_CYC + extra + 50) begin
      @(negedge clk);
      #1;
      i++;
    end
    check("done_seen", 32'(bus.Done), 1);
    check("first_rd_latency", first_rd_cyc - start_cyc, 1);
    check("done_latency", cyc - first_rd_cyc, RUN_CYC + extra);
    check("rd_total", rd_count, LOG2N * NB);
    check("wr_total", wr_count, LOG2N * NB);
    check("rd_queue_empty", 32'(exp_q.size()), 0);
    check("wr_queue_empty", 32'(wq.size()), 0);
    check("busy_in_done", 32'(bus.Busy), 0);
  endtask

  initial begin
    int rc;
    int wc;
    int pos;
    int st;
    logic prev_rd;
    issue_t e;
    issue_t prev_e;

    bus.Start  = 1'b0;
    bus.Ack    = 1'b0;
    bus.Hold   = 1'b0;
    bus2.Start = 1'b0;
    bus2.Ack   = 1'b0;
    bus2.Hold  = 1'b0;

    // Reset state.
    #12;
    check_zero("reset");
    #10;
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Run 1: no Hold; stray Start in RUN and early Ack must be ignored.
    start_run();
    wait_rd(100, 200);
    bus.Start = 1'b1;
    @(negedge clk);
    #1;
    bus.Start = 1'b0;
    wait_rd(600, 700);
    check("stage0_idle_gap", rd512_cyc - rd511_cyc, PIPE_LAT + 1);
    wait_rd(2000, 1600);
    bus.Ack = 1'b1;
    @(negedge clk);
    #1;
    bus.Ack = 1'b0;
    finish_run(0);
    repeat (3) @(negedge clk);
    #1;
    check("done_held", 32'(bus.Done), 1);

    // Ack in DONE: Done drops after the sampling edge; Ack held plus Start restarts.
    bus.Ack = 1'b1;
    @(posedge clk);
    #1;
    check("done_after_ack", 32'(bus.Done), 0);
    check("stage_cleared_idle", 32'(bus.stage), 9);
    start_run();
    bus.Ack = 1'b0;

    // Run 2: Hold for 7 cycles mid-stage-3, then Hold across one DRAIN.
    wait_rd(3 * NB + 100, 3 * RUN_CYC / LOG2N + 200);
    rc = rd_count;
    bus.Hold = 1'b1;
    repeat (7) @(negedge clk);
    #1;
    check("hold_no_issue", rd_count, rc);
    bus.Hold = 1'b0;
    wait_rd(6 * NB, 4 * RUN_CYC / LOG2N);
    bus.Hold = 1'b1;
    repeat (PIPE_LAT) @(negedge clk);
    #1;
    check("stage_after_held_drain", 32'(bus.stage), 6);
    bus.Hold = 1'b0;
    finish_run(7);
    bus.Ack = 1'b1;
    @(posedge clk);
    #1;
    bus.Ack = 1'b0;
    check("done_after_ack2", 32'(bus.Done), 0);
    @(negedge clk);
    #1;

    // Run 3: reset at stage 4, b 100 aborts with nothing left in flight.
    start_run();
    wait_rd(4 * NB + 101, 5 * RUN_CYC / LOG2N);
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    exp_q.delete();
    wq.delete();
    rc = rd_count;
    wc = wr_count;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("abort_no_wr", wr_count, wc);
    check("abort_no_rd", rd_count, rc);
    check("abort_no_done", 32'(bus.Done), 0);

    // Run 4: full transform after the abort.
    start_run();
    finish_run(0);
    bus.Ack = 1'b1;
    @(posedge clk);
    #1;
    bus.Ack = 1'b0;
    check("done_after_ack4", 32'(bus.Done), 0);

    // Small build, PIPE_LAT=1: one drain cycle, writes trail reads by one.
    @(negedge clk);
    #1;
    bus2.Start = 1'b1;
    @(posedge clk);
    #1;
    bus2.Start = 1'b0;
    prev_rd = 1'b0;
    prev_e  = model_issue(L2_S, 0, 0);
    for (int t = 0; t <= RUN_S; t++) begin
      logic exp_rd;
      @(posedge clk);
      #1;
      st     = t / (NB_S + PL_S);
      pos    = t % (NB_S + PL_S);
      exp_rd = (t < RUN_S) && (pos < NB_S);
      e      = model_issue(L2_S, st, pos);
      check("small_rd_en", 32'(bus2.rd_en), 32'(exp_rd));
      if (exp_rd) begin
        check("small_i_top",  32'(bus2.i_top),  e.top);
        check("small_i_bot",  32'(bus2.i_bot),  e.bot);
        check("small_tw_idx", 32'(bus2.tw_idx), e.tw);
        check("small_stage",  32'(bus2.stage),  st);
      end
      check("small_wr_en", 32'(bus2.wr_en), 32'(prev_rd));
      if (prev_rd) begin
        check("small_wr_top", 32'(bus2.wr_top), prev_e.top);
        check("small_wr_bot", 32'(bus2.wr_bot), prev_e.bot);
      end
      check("small_done", 32'(bus2.Done), 32'(t == RUN_S));
      prev_rd = exp_rd;
      prev_e  = e;
    end
    bus2.Ack = 1'b1;
    @(posedge clk);
    #1;
    bus2.Ack = 1'b0;
    check("small_done_after_ack", 32'(bus2.Done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
